mult_booth_seq: RTL and testbench

MULT_BOOTH_SEQ -- requirements
Module: mult_booth_seq

---
 rtl/mult_booth_seq_if.sv | 26 ++
 rtl/mult_booth_seq.sv | 120 ++++++++++++
 tb/tb_mult_booth_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mult_booth_seq_if.sv
// Request/result bundle for the sequential Booth multiplier.
//   start  : request strobe, sampled on rising clk
//   a, b   : signed 32-bit multiplicand / multiplier
//   busy   : multiplication in progress
//   done   : one-cycle pulse, new result on hi/lo
//   hi, lo : upper / lower halves of the signed 64-bit product
// master = requester side, slave = multiplier side.
interface mult_booth_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequential signed 32x32 -> 64 multiplier, radix-4 Booth, one recoded
// digit per clock, fixed 16-clock latency from accepted start to done.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_booth_seq_if.slave (start, a, b in; busy, done, hi, lo out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, hi/lo hold last result
// CALC  | one Booth iteration per edge, counter 0..15, start ignored
// DONE  | done pulse; start here launches the next operation at once
module mult_booth_seq (
    input  logic              clk,
    input  logic              rst_n,
    mult_booth_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] a_q;
    // {acc[33:0], multiplier[31:0], guard bit}; acc occupies [66:33]
    logic [66:0] prod_q;
    logic [66:0] prod_d;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        accept;
    logic        busy;
    logic        done;

    logic [33:0] acc;
    logic [33:0] a_ext;
    logic [33:0] a_dbl;
    logic [33:0] acc_sum;

    assign accept = bus.start && (state_q != S_CALC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_CALC;
            S_CALC: if (cnt_q == 4'd15) state_d = S_DONE;
            S_DONE: state_d = bus.start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_CALC:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Booth step: recode the low triplet, add the selected multiple of the
    // multiplicand into the accumulator, then arithmetic-shift the whole
    // register right by two.
    always_comb begin
        acc   = prod_q[66:33];
        a_ext = {{2{a_q[31]}}, a_q};
        a_dbl = {a_q[31], a_q, 1'b0};
        case (prod_q[2:0])
            3'b001, 3'b010: acc_sum = acc + a_ext;
            3'b011:         acc_sum = acc + a_dbl;
            3'b100:         acc_sum = acc - a_dbl;
            3'b101, 3'b110: acc_sum = acc - a_ext;
            default:        acc_sum = acc;
        endcase
        prod_d = {{2{acc_sum[33]}}, acc_sum, prod_q[32:2]};
    end

    // Datapath. After 16 shifts the 64-bit product sits in prod[64:1];
    // hi/lo only load on the last iteration so no partial sums leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (accept) begin
            a_q    <= bus.a;
            prod_q <= {34'd0, bus.b, 1'b0};
            cnt_q  <= '0;
        end else if (state_q == S_CALC) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                hi_q <= prod_d[64:33];
                lo_q <= prod_d[32:1];
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
module tb_mult_booth_seq;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cyc;

    mult_booth_seq_if bus_if ();

    mult_booth_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 if (clk_en) clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        return longint'(sx) * longint'(sy);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Present operands with start for one edge; caller is just past an edge.
    task automatic launch(input logic [31:0] op_a, input logic [31:0] op_b);
        bus_if.a     = op_a;
        bus_if.b     = op_b;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        busy_cyc = bus_if.busy ? 1 : 0;
    endtask

    // Edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.busy) busy_cyc++;
        end while (!bus_if.done && lat < 40);
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eh, input logic [31:0] el);
        int lat;
        launch(x, y);
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd16);
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd16);
        chk({tag, "_hi"}, {32'd0, bus_if.hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, bus_if.lo}, {32'd0, el});
        @(posedge clk);
        #1;
        chk({tag, "_done_single"}, {63'd0, bus_if.done}, 64'd0);
        chk({tag, "_hold_hi"}, {32'd0, bus_if.hi}, {32'd0, eh});
    endtask

    initial begin
        int lat;
        int dcount;
        int first;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;

        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        rst_n        = 1'b1;

        // Reset with no clock running
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hi",   {32'd0, bus_if.hi}, 64'd0);
        chk("rst_lo",   {32'd0, bus_if.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("rst_done", {63'd0, bus_if.done}, 64'd0);

        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("mixed_7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed("maxpos_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        directed("minneg_sq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        directed("minneg_x1", 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);

        // Start and operand changes while busy must be ignored
        launch(32'd5, 32'd6);
        dcount = 0;
        first  = 0;
        for (int k = 1; k <= 30; k++) begin
            bus_if.a     = $urandom;
            bus_if.b     = $urandom;
            bus_if.start = (k == 8);
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                dcount++;
                if (first == 0) first = k;
            end
        end
        bus_if.start = 1'b0;
        chk("ignore_done_count", 64'(dcount), 64'd1);
        chk("ignore_latency",    64'(first),  64'd16);
        chk("ignore_hi", {32'd0, bus_if.hi}, 64'd0);
        chk("ignore_lo", {32'd0, bus_if.lo}, 64'd30);

        // Back-to-back: second start accepted while in DONE
        launch(32'd5, 32'd6);
        wait_done(lat);
        chk("b2b_first_lat", 64'(lat), 64'd16);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b_busy_after_accept", {63'd0, bus_if.busy}, 64'd1);
        wait_done(lat);
        chk("b2b_second_lat", 64'(lat), 64'd16);
        chk("b2b_hi", {32'd0, bus_if.hi}, 64'd0);
        chk("b2b_lo", {32'd0, bus_if.lo}, 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a calculation
        launch(32'h1234_5678, 32'h0BAD_F00D);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_hi",   {32'd0, bus_if.hi}, 64'd0);
        chk("midrst_lo",   {32'd0, bus_if.lo}, 64'd0);
        chk("midrst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus_if.done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) dcount++;
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        directed("post_rst", 32'd0, 32'h1234_5678, 32'd0, 32'd0);

        // Randomized, chained back-to-back against the arithmetic reference
        for (int i = 0; i < 3000; i++) begin
            x = pick();
            y = pick();
            p = ref_prod(x, y);
            launch(x, y);
            wait_done(lat);
            chk("rand_latency", 64'(lat), 64'd16);
            chk("rand_hi", {32'd0, bus_if.hi}, {32'd0, p[63:32]});
            chk("rand_lo", {32'd0, bus_if.lo}, {32'd0, p[31:0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
